// File: rtl/key_expand_seq.sv
// rtl/key_expand_seq.sv - AES-128 key expansion, one S-box lookup per cycle
module key_expand_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] rk_out,
  output logic         rk_valid,
  output logic [3:0]   rk_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {IDLE, SUB, XOR} state_t;

  // S-box table, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_ROM = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  state_t      state;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] temp;
  logic [3:0]  r;
  logic [1:0]  b;

  logic [31:0] rot;
  logic [7:0]  sub_in;
  logic [7:0]  sub_out;
  logic [31:0] rcon;
  logic [31:0] t, n0, n1, n2, n3;

  // Shared S-box: pick byte b of RotWord(w3) and look it up.
  always_comb begin
    rot = {w3[23:0], w3[31:24]};
    case (b)
      2'd0:    sub_in = rot[31:24];
      2'd1:    sub_in = rot[23:16];
      2'd2:    sub_in = rot[15:8];
      default: sub_in = rot[7:0];
    endcase
    sub_out = SBOX_ROM[{~sub_in, 3'b000} +: 8];
  end

  // Round constant and the chained word XORs for the next round key.
  always_comb begin
    case (r)
      4'd1:    rcon = 32'h01000000;
      4'd2:    rcon = 32'h02000000;
      4'd3:    rcon = 32'h04000000;
      4'd4:    rcon = 32'h08000000;
      4'd5:    rcon = 32'h10000000;
      4'd6:    rcon = 32'h20000000;
      4'd7:    rcon = 32'h40000000;
      4'd8:    rcon = 32'h80000000;
      4'd9:    rcon = 32'h1b000000;
      4'd10:   rcon = 32'h36000000;
      default: rcon = 32'h00000000;
    endcase
    t  = temp ^ rcon;
    n0 = w0 ^ t;
    n1 = w1 ^ n0;
    n2 = w2 ^ n1;
    n3 = w3 ^ n2;
  end

  // Control FSM with registered outputs; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rk_out   <= '0;
      rk_idx   <= '0;
      rk_valid <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      r        <= '0;
      b        <= '0;
      w0       <= '0;
      w1       <= '0;
      w2       <= '0;
      w3       <= '0;
      temp     <= '0;
    end else begin
      rk_valid <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            w0       <= key_in[127:96];
            w1       <= key_in[95:64];
            w2       <= key_in[63:32];
            w3       <= key_in[31:0];
            rk_out   <= key_in;
            rk_valid <= 1'b1;
            rk_idx   <= 4'd0;
            r        <= 4'd1;
            b        <= 2'd0;
            busy     <= 1'b1;
            state    <= SUB;
          end
        end
        SUB: begin
          case (b)
            2'd0:    temp[31:24] <= sub_out;
            2'd1:    temp[23:16] <= sub_out;
            2'd2:    temp[15:8]  <= sub_out;
            default: temp[7:0]   <= sub_out;
          endcase
          b <= b + 2'd1;
          if (b == 2'd3) state <= XOR;
        end
        XOR: begin
          w0       <= n0;
          w1       <= n1;
          w2       <= n2;
          w3       <= n3;
          rk_out   <= {n0, n1, n2, n3};
          rk_valid <= 1'b1;
          rk_idx   <= r;
          b        <= 2'd0;
          if (r == 4'd10) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            r     <= r + 4'd1;
            state <= SUB;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_expand_seq.sv
// tb/tb_key_expand_seq.sv - self-checking bench for key_expand_seq
module tb_key_expand_seq;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic [127:0] rk_out;
  logic         rk_valid;
  logic [3:0]   rk_idx;
  logic         busy;
  logic         done;

  int n_assert;
  int n_fail;

  logic [7:0]   sb [256];
  logic [127:0] got_rk [11];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  key_expand_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .rk_out   (rk_out),
    .rk_valid (rk_valid),
    .rk_idx   (rk_idx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GF(2^8) arithmetic for deriving the S-box from first principles.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] m);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] v);
    return {v[6:0], v[7]};
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] v;
      logic [7:0] acc;
      v = x[7:0];
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, v);
      end
      acc = inv;
      v = inv;
      for (int k = 0; k < 4; k++) begin
        v = rotl1(v);
        acc = acc ^ v;
      end
      sb[x] = acc ^ 8'h63;
    end
  endtask

  // Word-oriented key schedule returning round key idx.
  function automatic logic [127:0] model_rk(input logic [127:0] key, input int idx);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h000000};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    step();
    start  = 1'b0;
    key_in = rand128();
  endtask

  // Observe cycles +1..+51 after a start edge; optional extra start at poke_at,
  // optional early return at abort_at (observed, not stepped past).
  task automatic run(input logic [127:0] k, input int poke_at, input int abort_at);
    logic [127:0] exp_rk [11];
    logic [127:0] last_rk;
    logic [3:0]   last_idx;
    int           pulses;
    bit           ev;
    int           ki;
    for (int i = 0; i < 11; i++) exp_rk[i] = model_rk(k, i);
    pulses   = 0;
    last_rk  = '0;
    last_idx = '0;
    for (int c = 1; c <= 51; c++) begin
      ev = ((c - 1) % 5 == 0);
      ki = (c - 1) / 5;
      chk($sformatf("rk_valid@%0d", c), {127'd0, rk_valid}, {127'd0, ev});
      chk($sformatf("done@%0d", c), {127'd0, done}, {127'd0, (c == 51)});
      chk($sformatf("busy@%0d", c), {127'd0, busy}, {127'd0, (c != 51)});
      if (ev) begin
        pulses++;
        last_idx = ki[3:0];
        last_rk  = exp_rk[ki];
        got_rk[ki] = rk_out;
      end
      chk($sformatf("rk_idx@%0d", c), {124'd0, rk_idx}, {124'd0, last_idx});
      chk($sformatf("rk_out@%0d", c), rk_out, last_rk);
      if (c == abort_at) return;
      if (c == 51) break;
      start  = (c == poke_at);
      key_in = rand128();
      step();
    end
    start = 1'b0;
    chk("pulse_count", 128'(pulses), 128'd11);
  endtask

  // Idle cycle after a completed run: strobes low, idx/key held.
  task automatic post_check(input logic [127:0] k);
    step();
    chk("post_valid", {127'd0, rk_valid}, 128'd0);
    chk("post_done", {127'd0, done}, 128'd0);
    chk("post_busy", {127'd0, busy}, 128'd0);
    chk("post_idx", {124'd0, rk_idx}, 128'd10);
    chk("post_rk", rk_out, model_rk(k, 10));
  endtask

  initial begin
    logic [127:0] ka;
    logic [127:0] kb;
    n_assert = 0;
    n_fail   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    key_in   = '0;
    build_sbox();

    step();
    step();
    chk("reset_rk", rk_out, 128'd0);
    chk("reset_valid", {127'd0, rk_valid}, 128'd0);
    chk("reset_idx", {124'd0, rk_idx}, 128'd0);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    chk("reset_done", {127'd0, done}, 128'd0);
    rst = 1'b0;
    step();
    chk("idle_valid", {127'd0, rk_valid}, 128'd0);

    // FIPS-197 key with an ignored start at +20 and key_in churn.
    launch(FIPS_KEY);
    run(FIPS_KEY, 20, 0);
    chk("fips_idx0", got_rk[0], FIPS_KEY);
    chk("fips_idx1", got_rk[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("fips_idx10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    post_check(FIPS_KEY);

    // All-zero key.
    launch(128'd0);
    run(128'd0, 0, 0);
    chk("zero_idx1", got_rk[1], 128'h62636363626363636263636362636363);
    post_check(128'd0);

    // Reset mid-expansion at +30 with a simultaneous start.
    ka = rand128();
    launch(ka);
    run(ka, 0, 30);
    rst    = 1'b1;
    start  = 1'b1;
    key_in = rand128();
    step();
    rst   = 1'b0;
    start = 1'b0;
    chk("abort_rk", rk_out, 128'd0);
    chk("abort_valid", {127'd0, rk_valid}, 128'd0);
    chk("abort_idx", {124'd0, rk_idx}, 128'd0);
    chk("abort_busy", {127'd0, busy}, 128'd0);
    chk("abort_done", {127'd0, done}, 128'd0);
    for (int i = 0; i < 60; i++) begin
      step();
      chk("quiet_strobe", {126'd0, rk_valid, done}, 128'd0);
      chk("quiet_busy", {127'd0, busy}, 128'd0);
    end
    launch(FIPS_KEY);
    run(FIPS_KEY, 0, 0);
    chk("after_rst_idx10", got_rk[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    post_check(FIPS_KEY);

    // Back-to-back: second start in the done cycle.
    ka = rand128();
    kb = rand128();
    launch(ka);
    run(ka, 0, 0);
    launch(kb);
    run(kb, 0, 0);
    post_check(kb);

    // Random keys.
    for (int n = 0; n < 3; n++) begin
      ka = rand128();
      launch(ka);
      run(ka, $urandom_range(2, 50), 0);
      post_check(ka);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
